// File: rtl/aes_v2_pkg.sv
// Shared definitions for the aes_v2 round sequencer: FSM encoding, op-select
// constants and word-index helpers for the 4-word AES state.
package aes_v2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_SUB_GAP,
        S_MIX,
        S_MIX_GAP,
        S_KEY,
        S_RSP
    } state_t;

    typedef logic [3:0][31:0] words_t;

    localparam logic SUB = 1'b1;
    localparam logic MIX = 1'b0;

    function automatic logic [1:0] word_next(input logic [1:0] k);
        return k + 2'd1;
    endfunction

    function automatic logic [1:0] word_prev(input logic [1:0] k);
        return k - 2'd1;
    endfunction

endpackage

// File: rtl/aes_v2_op_watchdog.sv
// Counts stalled cycles of the outstanding op and pulses abort when the
// stall reaches TIMEOUT cycles; TIMEOUT = 0 turns the watchdog off.
module aes_v2_op_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic busy,
    input  logic done,
    output logic abort
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;
    logic          stall;

    assign stall = busy && !done;
    // abort fires on the TIMEOUT-th stalled cycle, so cnt never exceeds TIMEOUT-1
    assign abort = (TIMEOUT != 0) && stall && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            cnt <= '0;
        else if (!stall || abort)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/aes_v2_round_seq.sv
// Drives four SubBytes/ShiftRows ops, four MixColumns ops (skipped on the last
// round) and the round-key XOR through one aes_v2 execution unit.
module aes_v2_round_seq
    import aes_v2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_enc,
    input  logic         req_last,
    input  logic         req_rot,
    input  logic [127:0] req_state,
    input  logic [127:0] req_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state,
    output logic         rsp_err,
    output logic         aes_valid,
    output logic         aes_sub,
    output logic [31:0]  aes_rs1,
    output logic [31:0]  aes_rs2,
    output logic         aes_enc,
    output logic         aes_rot,
    input  logic         aes_ready,
    input  logic [31:0]  aes_rd
);

    state_t     state, state_nxt;
    words_t     s_w, t_w, u_w, key_w, rsp_w;
    logic       enc_q, last_q, rot_q, err_q;
    logic [1:0] k;
    logic       op_done, abort;

    assign op_done   = aes_valid && aes_ready;
    assign rsp_state = rsp_w;
    assign rsp_err   = err_q;
    assign aes_enc   = enc_q;

    aes_v2_op_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .busy    (aes_valid),
        .done    (aes_ready),
        .abort   (abort)
    );

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        aes_valid = 1'b0;
        aes_sub   = MIX;
        aes_rot   = 1'b0;
        aes_rs1   = '0;
        aes_rs2   = '0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_SUB;
            end
            S_SUB: begin
                aes_valid = 1'b1;
                aes_sub   = SUB;
                aes_rot   = rot_q;
                aes_rs1   = s_w[k];
                aes_rs2   = enc_q ? s_w[word_next(k)] : s_w[word_prev(k)];
                if (abort)        state_nxt = S_RSP;
                else if (op_done) state_nxt = S_SUB_GAP;
            end
            // k has already wrapped to 0 in the gap after the fourth op
            S_SUB_GAP: begin
                if (k != 2'd0)   state_nxt = S_SUB;
                else if (last_q) state_nxt = S_KEY;
                else             state_nxt = S_MIX;
            end
            S_MIX: begin
                aes_valid = 1'b1;
                aes_rs1   = t_w[k];
                aes_rs2   = t_w[word_next(k)];
                if (abort)        state_nxt = S_RSP;
                else if (op_done) state_nxt = S_MIX_GAP;
            end
            S_MIX_GAP: state_nxt = (k == 2'd0) ? S_KEY : S_MIX;
            S_KEY:     state_nxt = S_RSP;
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            s_w    <= '0;
            t_w    <= '0;
            u_w    <= '0;
            key_w  <= '0;
            rsp_w  <= '0;
            enc_q  <= 1'b0;
            last_q <= 1'b0;
            rot_q  <= 1'b0;
            err_q  <= 1'b0;
            k      <= 2'd0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                s_w    <= req_state;
                key_w  <= req_key;
                enc_q  <= req_enc;
                last_q <= req_last;
                rot_q  <= req_rot;
                err_q  <= 1'b0;
                k      <= 2'd0;
            end
            if (abort) begin
                rsp_w <= '0;
                err_q <= 1'b1;
                k     <= 2'd0;
            end else if (op_done) begin
                if (state == S_SUB) t_w[k] <= aes_rd;
                else                u_w[k] <= aes_rd;
                k <= k + 2'd1;
            end
            if (state == S_KEY) begin
                rsp_w <= (last_q ? t_w : u_w) ^ key_w;
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_v2_round_seq.sv
// Self-checking bench: XOR stub responder with optional random delay, op
// monitor, and a word-level reference model of one aes_v2 round.
module tb_aes_v2_round_seq;

    localparam int unsigned TO = 4;

    logic         g_clk = 1'b0;
    logic         g_reset;
    logic         req_valid, req_ready, req_enc, req_last, req_rot;
    logic [127:0] req_state, req_key;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [127:0] rsp_state;
    logic         aes_valid, aes_sub, aes_enc, aes_rot, aes_ready;
    logic [31:0]  aes_rs1, aes_rs2, aes_rd;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    aes_v2_round_seq #(.TIMEOUT(TO)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_enc   (req_enc),
        .req_last  (req_last),
        .req_rot   (req_rot),
        .req_state (req_state),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_state (rsp_state),
        .rsp_err   (rsp_err),
        .aes_valid (aes_valid),
        .aes_sub   (aes_sub),
        .aes_rs1   (aes_rs1),
        .aes_rs2   (aes_rs2),
        .aes_enc   (aes_enc),
        .aes_rot   (aes_rot),
        .aes_ready (aes_ready),
        .aes_rd    (aes_rd)
    );

    // stub execution unit: rd = rs1 ^ rs2, ready on the cur_delay-th valid cycle
    logic never_ready = 1'b0;
    logic rand_delay  = 1'b0;
    int   cur_delay   = 1;
    int   wait_cnt    = 0;

    assign aes_ready = aes_valid && !never_ready && (wait_cnt >= cur_delay - 1);
    assign aes_rd    = aes_rs1 ^ aes_rs2;

    always @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wait_cnt <= 0;
        end else if (aes_valid && aes_ready) begin
            wait_cnt  <= 0;
            cur_delay <= rand_delay ? int'($urandom_range(1, 4)) : 1;
        end else if (aes_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // op monitor: one entry per completed op
    int          cyc = 0;
    int          valid_cycles = 0;
    logic        in_op = 1'b0;
    logic        stab;
    logic [31:0] r1, r2;
    int          st_cyc;
    logic        q_sub[$], q_rot[$], q_enc[$], q_stab[$];
    logic [31:0] q_rs1[$], q_rs2[$];
    int          q_start[$], q_end[$];

    always @(negedge g_clk) begin
        cyc = cyc + 1;
        if (aes_valid) begin
            valid_cycles = valid_cycles + 1;
            if (!in_op) begin
                in_op = 1'b1; st_cyc = cyc; r1 = aes_rs1; r2 = aes_rs2; stab = 1'b1;
            end else if (aes_rs1 !== r1 || aes_rs2 !== r2) begin
                stab = 1'b0;
            end
            if (aes_ready) begin
                q_sub.push_back(aes_sub);   q_rot.push_back(aes_rot);
                q_enc.push_back(aes_enc);   q_stab.push_back(stab);
                q_rs1.push_back(aes_rs1);   q_rs2.push_back(aes_rs2);
                q_start.push_back(st_cyc);  q_end.push_back(cyc);
                in_op = 1'b0;
            end
        end else begin
            in_op = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: t = sub-op results, u = mix-op results, out = (last ? t : u) ^ key
    function automatic logic [127:0] model(input logic e, input logic l,
                                           input logic [127:0] st, input logic [127:0] key);
        logic [3:0][31:0] s, t, u, kk, o;
        s = st; kk = key;
        for (int i = 0; i < 4; i++) t[i] = s[i] ^ s[e ? (i + 1) % 4 : (i + 3) % 4];
        for (int i = 0; i < 4; i++) u[i] = t[i] ^ t[(i + 1) % 4];
        for (int i = 0; i < 4; i++) o[i] = (l ? t[i] : u[i]) ^ kk[i];
        return o;
    endfunction

    task automatic check_ops(input logic e, input logic l, input logic r,
                             input logic [127:0] st, input int base);
        logic [3:0][31:0] s, t;
        int n, k, j;
        logic sb;
        s = st;
        for (int i = 0; i < 4; i++) t[i] = s[i] ^ s[e ? (i + 1) % 4 : (i + 3) % 4];
        n = l ? 4 : 8;
        chk("op_count", 128'(q_rs1.size() - base), 128'(n));
        for (int i = 0; i < n; i++) begin
            j  = base + i;
            k  = i % 4;
            sb = (i < 4);
            if (j < q_rs1.size()) begin
                chk("op_sub", q_sub[j], sb);
                chk("op_rs1", q_rs1[j], sb ? s[k] : t[k]);
                chk("op_rs2", q_rs2[j], sb ? s[e ? (k + 1) % 4 : (k + 3) % 4] : t[(k + 1) % 4]);
                chk("op_rot", q_rot[j], sb ? r : 1'b0);
                chk("op_enc", q_enc[j], e);
                chk("op_stable", q_stab[j], 1'b1);
                if (i > 0) chk("op_gap", 128'(q_start[j]), 128'(q_end[j - 1] + 2));
            end
        end
    endtask

    task automatic run_round(input logic e, input logic l, input logic r,
                             input logic [127:0] st, input logic [127:0] key, input int hold,
                             output logic [127:0] res, output logic err, output int lat);
        @(negedge g_clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_enc = e; req_last = l; req_rot = r; req_state = st; req_key = key;
        req_valid = 1'b1;
        @(posedge g_clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge g_clk);
            #1 lat++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
        res = rsp_state;
        err = rsp_err;
        repeat (hold) begin
            @(negedge g_clk);
            chk("rsp_hold_valid", rsp_valid, 1'b1);
            chk("rsp_hold_state", rsp_state, res);
        end
        @(negedge g_clk);
        rsp_ready = 1'b1;
        @(posedge g_clk);
        #1 rsp_ready = 1'b0;
        @(negedge g_clk);
        chk("rsp_single_accept", rsp_valid, 1'b0);
        chk("req_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] st0, key, res, st;
        logic         err, e, l, r, found;
        int           lat, base, vbase;

        st0 = {32'h8, 32'h4, 32'h2, 32'h1};
        g_reset = 1'b1; req_valid = 1'b0; req_enc = 1'b0; req_last = 1'b0; req_rot = 1'b0;
        req_state = '0; req_key = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_aes_valid", aes_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_state", rsp_state, '0);
        chk("rst_aes_rs1", aes_rs1, '0);
        chk("rst_aes_sub", aes_sub, 1'b0);
        @(negedge g_clk);
        g_reset = 1'b0;

        // enc, last round
        base = q_rs1.size();
        run_round(1'b1, 1'b1, 1'b1, st0, '0, 0, res, err, lat);
        chk("enc_last_state", res, {32'h9, 32'hC, 32'h6, 32'h3});
        chk("enc_last_lat", 128'(lat), 128'(9));
        chk("enc_last_err", err, 1'b0);
        check_ops(1'b1, 1'b1, 1'b1, st0, base);

        // enc, full round
        base = q_rs1.size();
        run_round(1'b1, 1'b0, 1'b0, st0, '0, 0, res, err, lat);
        chk("enc_full_state", res, {32'hA, 32'h5, 32'hA, 32'h5});
        chk("enc_full_lat", 128'(lat), 128'(17));
        check_ops(1'b1, 1'b0, 1'b0, st0, base);

        run_round(1'b1, 1'b0, 1'b0, st0, {4{32'hF}}, 0, res, err, lat);
        chk("enc_full_key", res, {32'h5, 32'hA, 32'h5, 32'hA});

        // dec, last round
        base = q_rs1.size();
        run_round(1'b0, 1'b1, 1'b0, st0, '0, 0, res, err, lat);
        chk("dec_last_state", res, {32'hC, 32'h6, 32'h3, 32'h9});
        check_ops(1'b0, 1'b1, 1'b0, st0, base);

        // multicycle responder
        rand_delay = 1'b1;
        base = q_rs1.size();
        run_round(1'b1, 1'b0, 1'b0, st0, '0, 0, res, err, lat);
        chk("slow_full_state", res, {32'hA, 32'h5, 32'hA, 32'h5});
        check_ops(1'b1, 1'b0, 1'b0, st0, base);
        for (int n = 0; n < 6; n++) begin
            e = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
            st  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            base = q_rs1.size();
            run_round(e, l, r, st, key, int'($urandom_range(0, 2)), res, err, lat);
            chk("rand_state", res, model(e, l, st, key));
            chk("rand_err", err, 1'b0);
            check_ops(e, l, r, st, base);
        end
        rand_delay = 1'b0;

        // watchdog abort, then a normal round
        never_ready = 1'b1;
        base = q_rs1.size();
        vbase = valid_cycles;
        run_round(1'b1, 1'b0, 1'b0, st0, {4{32'hF}}, 0, res, err, lat);
        chk("wdog_err", err, 1'b1);
        chk("wdog_state", res, '0);
        chk("wdog_lat", 128'(lat), 128'(TO));
        chk("wdog_valid_cycles", 128'(valid_cycles - vbase), 128'(TO));
        chk("wdog_no_ops", 128'(q_rs1.size() - base), '0);
        never_ready = 1'b0;
        run_round(1'b1, 1'b1, 1'b0, st0, '0, 0, res, err, lat);
        chk("post_wdog_state", res, {32'h9, 32'hC, 32'h6, 32'h3});
        chk("post_wdog_err", err, 1'b0);

        // reset during MIX with k = 2 (rs1 = t[2] = C)
        @(negedge g_clk);
        req_enc = 1'b1; req_last = 1'b0; req_rot = 1'b0; req_state = st0; req_key = '0;
        req_valid = 1'b1;
        @(posedge g_clk);
        #1 req_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge g_clk);
            if (aes_valid && !aes_sub && aes_rs1 == 32'hC) found = 1'b1;
        end
        chk("mix_k2_reached", found, 1'b1);
        #1 g_reset = 1'b1;
        #1;
        chk("rst_mid_aes_valid", aes_valid, 1'b0);
        chk("rst_mid_req_ready", req_ready, 1'b1);
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_rsp_valid", rsp_valid, 1'b0);
        base = q_rs1.size();
        run_round(1'b1, 1'b0, 1'b0, st0, '0, 5, res, err, lat);
        chk("post_rst_state", res, {32'hA, 32'h5, 32'hA, 32'h5});
        chk("post_rst_lat", 128'(lat), 128'(17));
        check_ops(1'b1, 1'b0, 1'b0, st0, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
